// File: rtl/t05_htree_builder.sv
// t05_htree_builder: writes one Huffman merge node per request, then rewrites child records of merged sum nodes.
// Ports: clk/rst (async active-high); in_valid_i/in_ready_o/least1_i/least2_i/sum_i request;
// wr_valid_i/o wr_ready_i/wr_addr_o/wr_data_o node SRAM write; rd_req_o/rd_addr_o/rd_valid_i/rd_data_i child read;
// merge_done_o pulse, tree_done_o and err_o sticky levels, node_count_o internal nodes created.
module t05_htree_builder #(
  parameter int IDX_W = 7,
  parameter int SUM_W = 46,
  parameter int RD_TIMEOUT = 15,
  localparam int ENT_W = IDX_W + 2,
  localparam int NODE_W = IDX_W + 2*ENT_W + SUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ENT_W-1:0]  least1_i,
  input  logic [ENT_W-1:0]  least2_i,
  input  logic [SUM_W-1:0]  sum_i,
  output logic              wr_valid_o,
  input  logic              wr_ready_i,
  output logic [IDX_W-1:0]  wr_addr_o,
  output logic [NODE_W-1:0] wr_data_o,
  output logic              rd_req_o,
  output logic [IDX_W-1:0]  rd_addr_o,
  input  logic              rd_valid_i,
  input  logic [2*ENT_W-1:0] rd_data_i,
  output logic              merge_done_o,
  output logic              tree_done_o,
  output logic              err_o,
  output logic [IDX_W-1:0]  node_count_o
);
  localparam int WT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [ENT_W-1:0] NULL_E = {2'b11, {IDX_W{1'b0}}};
  typedef enum logic [2:0] {IDLE, WR_NODE, RD1, WB1, RD2, WB2, DONE} state_t;
  state_t state_q;
  logic [ENT_W-1:0] l1_q, l2_q;
  logic [WT_W-1:0] wait_q;
  logic sn1, sn2, one_null;
  // A sum-node child is flagged by the top entry bit; NULL shares that bit but has no record.
  assign sn1 = l1_q[ENT_W-1] && (l1_q != NULL_E);
  assign sn2 = l2_q[ENT_W-1] && (l2_q != NULL_E);
  assign one_null = (l1_q == NULL_E) || (l2_q == NULL_E);
  assign in_ready_o = (state_q == IDLE) && !tree_done_o && !err_o;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      l1_q <= '0;
      l2_q <= '0;
      wait_q <= '0;
      node_count_o <= '0;
      wr_valid_o <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      rd_req_o <= 1'b0;
      rd_addr_o <= '0;
      merge_done_o <= 1'b0;
      tree_done_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      merge_done_o <= 1'b0;
      case (state_q)
        IDLE:
          if (in_valid_i && in_ready_o) begin
            l1_q <= least1_i;
            l2_q <= least2_i;
            if (least1_i == NULL_E && least2_i == NULL_E) tree_done_o <= 1'b1;
            else if (node_count_o == '1) err_o <= 1'b1;
            else begin
              state_q <= WR_NODE;
              wr_valid_o <= 1'b1;
              wr_addr_o <= node_count_o;
              wr_data_o <= {node_count_o, least1_i, least2_i, sum_i};
            end
          end
        WR_NODE:
          if (wr_ready_i) begin
            wr_valid_o <= 1'b0;
            node_count_o <= node_count_o + IDX_W'(1);
            wait_q <= '0;
            if (sn1) begin
              state_q <= RD1;
              rd_req_o <= 1'b1;
              rd_addr_o <= l1_q[IDX_W-1:0];
            end else if (sn2) begin
              state_q <= RD2;
              rd_req_o <= 1'b1;
              rd_addr_o <= l2_q[IDX_W-1:0];
            end else begin
              state_q <= DONE;
              merge_done_o <= 1'b1;
              tree_done_o <= tree_done_o | one_null;
            end
          end
        RD1, RD2:
          if (rd_valid_i) begin
            state_q <= (state_q == RD1) ? WB1 : WB2;
            rd_req_o <= 1'b0;
            wr_valid_o <= 1'b1;
            wr_addr_o <= rd_addr_o;
            wr_data_o <= {rd_addr_o, rd_data_i, {SUM_W{1'b0}}};
          end else if (wait_q == WT_W'(RD_TIMEOUT - 1)) begin
            state_q <= IDLE;
            rd_req_o <= 1'b0;
            err_o <= 1'b1;
          end else wait_q <= wait_q + WT_W'(1);
        WB1, WB2:
          if (wr_ready_i) begin
            wr_valid_o <= 1'b0;
            wait_q <= '0;
            if (state_q == WB1 && sn2) begin
              state_q <= RD2;
              rd_req_o <= 1'b1;
              rd_addr_o <= l2_q[IDX_W-1:0];
            end else begin
              state_q <= DONE;
              merge_done_o <= 1'b1;
              tree_done_o <= tree_done_o | one_null;
            end
          end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_t05_htree_builder.sv
// tb_t05_htree_builder: directed self-checking bench for t05_htree_builder.
module tb_t05_htree_builder;
  localparam int IDX_W = 7, SUM_W = 46, ENT_W = 9, NODE_W = 71;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid_i = 1'b0, in_ready_o;
  logic [ENT_W-1:0] least1_i = '0, least2_i = '0;
  logic [SUM_W-1:0] sum_i = '0;
  logic wr_valid_o, wr_ready_i = 1'b0;
  logic [IDX_W-1:0] wr_addr_o, rd_addr_o, node_count_o;
  logic [NODE_W-1:0] wr_data_o;
  logic rd_req_o, rd_valid_i = 1'b0;
  logic [2*ENT_W-1:0] rd_data_i = '0;
  logic merge_done_o, tree_done_o, err_o;
  int n_chk = 0, n_fail = 0;
  t05_htree_builder dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .least1_i(least1_i), .least2_i(least2_i), .sum_i(sum_i),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_valid_i(rd_valid_i), .rd_data_i(rd_data_i),
    .merge_done_o(merge_done_o), .tree_done_o(tree_done_o), .err_o(err_o), .node_count_o(node_count_o)
  );
  always #5 clk = ~clk;
  function automatic logic [NODE_W-1:0] node(input logic [IDX_W-1:0] i, input logic [ENT_W-1:0] a, b, input logic [SUM_W-1:0] s);
    return {i, a, b, s};
  endfunction
  function automatic logic [NODE_W-1:0] child(input logic [IDX_W-1:0] i, input logic [2*ENT_W-1:0] d);
    return {i, d, {SUM_W{1'b0}}};
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic reset_chk(input string tag);
    chk({tag, ".in_ready"}, in_ready_o, 1);
    chk({tag, ".wr_valid"}, wr_valid_o, 0);
    chk({tag, ".rd_req"}, rd_req_o, 0);
    chk({tag, ".merge_done"}, merge_done_o, 0);
    chk({tag, ".tree_done"}, tree_done_o, 0);
    chk({tag, ".err"}, err_o, 0);
    chk({tag, ".node_count"}, node_count_o, 0);
    chk({tag, ".wr_addr"}, wr_addr_o, 0);
    chk({tag, ".wr_data"}, wr_data_o, 0);
    chk({tag, ".rd_addr"}, rd_addr_o, 0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid_i = 1'b0;
    wr_ready_i = 1'b0;
    rd_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic send(input logic [ENT_W-1:0] a, b, input logic [SUM_W-1:0] s);
    chk("send.in_ready", in_ready_o, 1);
    in_valid_i = 1'b1;
    least1_i = a;
    least2_i = b;
    sum_i = s;
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask
  task automatic wr_ok(input string tag, input logic [IDX_W-1:0] a, input logic [NODE_W-1:0] d);
    chk({tag, ".wr_valid"}, wr_valid_o, 1);
    chk({tag, ".rd_req"}, rd_req_o, 0);
    chk({tag, ".wr_addr"}, wr_addr_o, a);
    chk({tag, ".wr_data"}, wr_data_o, d);
    wr_ready_i = 1'b1;
    @(negedge clk);
    wr_ready_i = 1'b0;
  endtask
  task automatic wr_stall(input string tag, input logic [IDX_W-1:0] a, input logic [NODE_W-1:0] d);
    wr_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, ".st_valid"}, wr_valid_o, 1);
      chk({tag, ".st_rd_req"}, rd_req_o, 0);
      chk({tag, ".st_data"}, wr_data_o, d);
      rd_valid_i = (i == 1);
      rd_data_i = (i == 1) ? 18'h3FFFF : 18'h0;
      @(negedge clk);
    end
    rd_valid_i = 1'b0;
    wr_ok(tag, a, d);
  endtask
  task automatic rd_serve(input string tag, input logic [IDX_W-1:0] a, input logic [2*ENT_W-1:0] d, input int dly);
    for (int i = 0; i < dly; i++) begin
      chk({tag, ".wait_req"}, rd_req_o, 1);
      chk({tag, ".wait_wr"}, wr_valid_o, 0);
      @(negedge clk);
    end
    chk({tag, ".rd_req"}, rd_req_o, 1);
    chk({tag, ".rd_addr"}, rd_addr_o, a);
    rd_valid_i = 1'b1;
    rd_data_i = d;
    @(negedge clk);
    rd_valid_i = 1'b0;
    rd_data_i = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1);
  end
  initial begin
    do_reset();
    reset_chk("rst0");
    // two leaves
    send(9'h005, 9'h012, 46'd7);
    wr_ok("leaf", 0, node(0, 9'h005, 9'h012, 46'd7));
    chk("leaf.merge_done", merge_done_o, 1);
    chk("leaf.wr_valid_off", wr_valid_o, 0);
    chk("leaf.count", node_count_o, 1);
    @(negedge clk);
    chk("leaf.done_pulse", merge_done_o, 0);
    chk("leaf.ready", in_ready_o, 1);
    // one sum-node child, delayed read
    send(9'h100, 9'h003, 46'd5);
    wr_ok("one", 1, node(1, 9'h100, 9'h003, 46'd5));
    rd_serve("one.rd", 0, 18'h0A0C0, 3);
    wr_ok("one.wb", 0, child(0, 18'h0A0C0));
    chk("one.merge_done", merge_done_o, 1);
    chk("one.count", node_count_o, 2);
    @(negedge clk);
    // both sum nodes, stalled writes, stray rd_valid ignored
    send(9'h101, 9'h100, 46'd9);
    wr_stall("two.node", 2, node(2, 9'h101, 9'h100, 46'd9));
    rd_serve("two.rd1", 1, 18'h00111, 1);
    wr_stall("two.wb1", 1, child(1, 18'h00111));
    rd_serve("two.rd2", 0, 18'h00222, 0);
    wr_stall("two.wb2", 0, child(0, 18'h00222));
    chk("two.merge_done", merge_done_o, 1);
    chk("two.count", node_count_o, 3);
    @(negedge clk);
    // single symbol: tree completes
    send(9'h007, 9'h180, 46'd3);
    wr_ok("single", 3, node(3, 9'h007, 9'h180, 46'd3));
    chk("single.merge_done", merge_done_o, 1);
    chk("single.tree_done", tree_done_o, 1);
    @(negedge clk);
    chk("single.ready", in_ready_o, 0);
    in_valid_i = 1'b1;
    least1_i = 9'h180;
    least2_i = 9'h180;
    repeat (3) @(negedge clk);
    in_valid_i = 1'b0;
    chk("ignored.wr_valid", wr_valid_o, 0);
    chk("ignored.count", node_count_o, 4);
    chk("ignored.tree_done", tree_done_o, 1);
    chk("ignored.merge_done", merge_done_o, 0);
    // read timeout
    do_reset();
    reset_chk("rst1");
    send(9'h100, 9'h001, 46'd1);
    wr_ok("to", 0, node(0, 9'h100, 9'h001, 46'd1));
    for (int i = 0; i < 15; i++) begin
      chk("to.rd_req", rd_req_o, 1);
      chk("to.err_early", err_o, 0);
      @(negedge clk);
    end
    chk("to.err", err_o, 1);
    chk("to.rd_req_off", rd_req_o, 0);
    chk("to.ready", in_ready_o, 0);
    in_valid_i = 1'b1;
    least1_i = 9'h005;
    least2_i = 9'h006;
    repeat (2) @(negedge clk);
    in_valid_i = 1'b0;
    chk("to.no_wr", wr_valid_o, 0);
    chk("to.err_sticky", err_o, 1);
    // node counter full
    do_reset();
    in_valid_i = 1'b1;
    least1_i = 9'h001;
    least2_i = 9'h002;
    sum_i = 46'd1;
    wr_ready_i = 1'b1;
    for (int i = 0; i < 600 && node_count_o != 7'd127; i++) @(negedge clk);
    in_valid_i = 1'b0;
    wr_ready_i = 1'b0;
    chk("full.count", node_count_o, 127);
    @(negedge clk);
    send(9'h001, 9'h002, 46'd1);
    chk("full.err", err_o, 1);
    chk("full.no_wr", wr_valid_o, 0);
    chk("full.no_wrap", node_count_o, 127);
    chk("full.ready", in_ready_o, 0);
    // reset in the middle of RD2
    do_reset();
    send(9'h005, 9'h102, 46'd2);
    wr_ok("mid", 0, node(0, 9'h005, 9'h102, 46'd2));
    chk("mid.rd_req", rd_req_o, 1);
    chk("mid.rd_addr", rd_addr_o, 2);
    #2 rst = 1'b1;
    #1 reset_chk("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    wr_ready_i = 1'b1;
    rd_valid_i = 1'b1;
    @(negedge clk);
    rd_valid_i = 1'b0;
    wr_ready_i = 1'b0;
    chk("mid.after_wr", wr_valid_o, 0);
    chk("mid.after_rd", rd_req_o, 0);
    chk("mid.after_done", merge_done_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/t05_htree_builder.md
T05_HTREE_BUILDER -- requirements
Module: t05_htree_builder

Parameters
REQ-001 SHALL have parameter IDX_W, default 7; width of node index and node counter.
REQ-002 SHALL have parameter SUM_W, default 46; width of frequency sum.
REQ-003 SHALL have parameter RD_TIMEOUT, default 15; maximum cycles waiting for rd_valid.
REQ-004 SHALL derive ENT_W = IDX_W+2 (entry: bit ENT_W-1 = sum-node flag; NULL entry = 2'b11 followed by IDX_W zeros) and NODE_W = IDX_W + 2*ENT_W + SUM_W.

Interface
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 in_valid  in  1  merge request present.
REQ-008 in_ready  out  1  block accepts request this cycle.
REQ-009 least1, least2  in  ENT_W  two least-frequent entries.
REQ-010 sum  in  SUM_W  combined frequency.
REQ-011 wr_valid  out  1  write record valid.
REQ-012 wr_ready  in  1  SRAM accepts write.
REQ-013 wr_addr  out  IDX_W  write address.
REQ-014 wr_data  out  NODE_W  record to write.
REQ-015 rd_req  out  1  child-record read request, level.
REQ-016 rd_addr  out  IDX_W  read address.
REQ-017 rd_valid  in  1  rd_data valid, single-cycle pulse.
REQ-018 rd_data  in  2*ENT_W  child-entry field of the record read.
REQ-019 merge_done  out  1  one-cycle pulse, merge fully written.
REQ-020 tree_done  out  1  level; tree complete.
REQ-021 err  out  1  sticky error.
REQ-022 node_count  out  IDX_W  internal nodes created.

Function
REQ-023 SHALL implement states IDLE, WR_NODE, RD1, WB1, RD2, WB2, DONE.
REQ-024 IDLE: in_ready=1 unless tree_done or err; handshake (in_valid & in_ready) SHALL register least1, least2, sum.
REQ-025 Accept with least1 = least2 = NULL: SHALL set tree_done, no write, remain IDLE.
REQ-026 Any other accepted request: SHALL go to WR_NODE.
REQ-027 WR_NODE: wr_valid=1, wr_addr=node_count, wr_data={node_count, least1, least2, sum}; on wr_ready SHALL increment node_count, then go RD1 if least1 is a non-NULL sum node, else RD2 if least2 is one, else DONE.
REQ-028 Exactly one entry NULL (single-symbol input): SHALL write node normally, skip child reads, and set tree_done on entering DONE.
REQ-029 RD1/RD2: rd_req=1, rd_addr=child index (low IDX_W bits of least1/least2) until rd_valid; rd_data SHALL be captured on the rd_valid cycle.
REQ-030 WB1/WB2: wr_valid=1, wr_addr=child index, wr_data={child index, captured rd_data, SUM_W zeros}; on wr_ready WB1 goes RD2 if least2 is a non-NULL sum node else DONE; WB2 goes DONE.
REQ-031 DONE: merge_done=1 for exactly one cycle, then IDLE.
REQ-032 wr_valid and wr_data SHALL stay stable while wr_ready=0; wr_valid and rd_req SHALL never be high together.
REQ-033 Wait counter SHALL clear on each RD entry; reaching RD_TIMEOUT cycles without rd_valid SHALL set err and go IDLE.
REQ-034 Accepting a non-NULL-pair request with node_count = 2^IDX_W-1 SHALL set err, no write, remain IDLE (no wrap).
REQ-035 err and tree_done SHALL hold until rst; in_ready=0 while either set.
REQ-036 rd_valid outside RD1/RD2 SHALL be ignored.

Reset
REQ-037 rst high SHALL immediately force IDLE; node_count=0; in_ready=1; wr_valid, rd_req, merge_done, tree_done, err=0; wr_addr, wr_data, rd_addr=0; captured registers and wait counter=0.
REQ-038 rst mid-operation SHALL abandon the merge without completing pending write or read.

Verification
REQ-039 Leaves 0x005, 0x012, sum 7, wr_ready=1 -> one write at addr 0 with {0,0x005,0x012,7}; merge_done 2 cycles after accept; node_count=1.
REQ-040 least1=0x100 (sum node 0), least2=0x003, rd_data=0x0A0C0 after 3-cycle delay -> writes addr 1 then addr 0 with {0,0x0A0C0,0}; merge_done; node_count=2.
REQ-041 Both entries sum nodes, wr_ready low 4 cycles on each write -> data stable while stalled; order node, child1, child2.
REQ-042 least1=0x007, least2=NULL (0x180) -> one write, then tree_done=1, in_ready=0; next request with both NULL ignored.
REQ-043 rd_valid never asserted -> err=1 after RD_TIMEOUT cycles in RD1, in_ready=0 until rst.
REQ-044 node_count=127, non-NULL request accepted -> err=1, no write; rst mid-RD2 -> all outputs at reset values same cycle.
